// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
//
// Purpose:
//   Control-side companion of the datapath ALU. Decodes ALUOp/funct into the
//   4-bit ALU_Control code, owns the HI/LO registers, and runs signed mult/div
//   iteratively (radix-2, one bit per cycle). A valid/ready handshake lets the
//   main control FSM stall while a multi-cycle operation is in flight.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   op_valid     operation request (taken only while op_ready is high)
//   op_ready     high only in IDLE
//   ALUOp        main-control op class
//   funct        R-type function field
//   rs_data      operand A (mult multiplicand / div dividend)
//   rt_data      operand B (mult multiplier / div divisor)
//   ALU_Control  code to the ALU, held until the next accepted op
//   use_hilo     writeback selects hilo_result instead of the ALU result
//   hilo_result  HI or LO value for mfhi/mflo
//   done         one-cycle completion pulse
//   illegal      valid with done; unsupported encoding
//   div_zero     valid with done; divide by zero
//   hi_out       current HI
//   lo_out       current LO
// ---------------------------------------------------------------------------
module alu_control_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [1:0]      ALUOp,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [3:0]      ALU_Control,
    output logic            use_hilo,
    output logic [XLEN-1:0] hilo_result,
    output logic            done,
    output logic            illegal,
    output logic            div_zero,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int CW = $clog2(XLEN);

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_MULT,
        OP_DIV,
        OP_MFHI,
        OP_MFLO,
        OP_ILLEGAL
    } opKind_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     opA_q, opA_d;
    logic [XLEN-1:0]     opB_q, opB_d;
    // mult: {partial product high, multiplier/product low}
    // div:  {partial remainder, dividend/quotient}
    logic [2*XLEN-1:0]   work_q, work_d;
    logic                negRes_q, negRes_d;
    logic                negRem_q, negRem_d;
    logic                isDiv_q, isDiv_d;
    logic [3:0]          aluCtl_q, aluCtl_d;
    logic                useHilo_q, useHilo_d;
    logic [XLEN-1:0]     hiloRes_q, hiloRes_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;
    logic                divZero_q, divZero_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;

    opKind_t             opKind;
    logic [3:0]          decCode;
    logic [XLEN-1:0]     absRs, absRt;
    logic [XLEN:0]       mulSum;
    logic [2*XLEN-1:0]   mulNext;
    logic [XLEN:0]       divShift, divDiff;
    logic [XLEN-1:0]     divRem;
    logic                divBit;
    logic [2*XLEN-1:0]   divNext;
    logic [2*XLEN-1:0]   prodFixed;
    logic [XLEN-1:0]     quoFixed, remFixed;
    logic                accept;

    assign accept = op_valid && (state_q == IDLE);

    // Instruction decode: classifies the request and yields the ALU code
    // for the plain ALU operations.
    always_comb begin : decodeLogic
        opKind  = OP_ILLEGAL;
        decCode = 4'b0000;
        case (ALUOp)
            2'b00: begin opKind = OP_ALU; decCode = 4'b0010; end
            2'b01: begin opKind = OP_ALU; decCode = 4'b0110; end
            2'b11: begin opKind = OP_ALU; decCode = 4'b0111; end
            default: begin
                case (funct)
                    FN_ADD:  begin opKind = OP_ALU; decCode = 4'b0010; end
                    FN_SUB:  begin opKind = OP_ALU; decCode = 4'b0110; end
                    FN_AND:  begin opKind = OP_ALU; decCode = 4'b0000; end
                    FN_OR:   begin opKind = OP_ALU; decCode = 4'b0001; end
                    FN_NOR:  begin opKind = OP_ALU; decCode = 4'b1100; end
                    FN_SLT:  begin opKind = OP_ALU; decCode = 4'b0111; end
                    FN_MULT: opKind = OP_MULT;
                    FN_DIV:  opKind = OP_DIV;
                    FN_MFHI: opKind = OP_MFHI;
                    FN_MFLO: opKind = OP_MFLO;
                    default: opKind = OP_ILLEGAL;
                endcase
            end
        endcase
    end

    // Iteration datapath: operand magnitudes, one shift-add multiply step,
    // one restoring divide step, and the final sign fix-up.
    always_comb begin : iterDatapath
        absRs = rs_data[XLEN-1] ? (~rs_data + 1'b1) : rs_data;
        absRt = rt_data[XLEN-1] ? (~rt_data + 1'b1) : rt_data;

        // Add the multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole pair right.
        mulSum  = {1'b0, work_q[2*XLEN-1:XLEN]}
                + (work_q[0] ? {1'b0, opA_q} : {(XLEN+1){1'b0}});
        mulNext = {mulSum, work_q[XLEN-1:1]};

        // Shift the next dividend bit into the remainder and try to
        // subtract; a borrow in the top bit means the divisor did not fit.
        divShift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        divDiff  = divShift - {1'b0, opB_q};
        divBit   = ~divDiff[XLEN];
        divRem   = divBit ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
        divNext  = {divRem, work_q[XLEN-2:0], divBit};

        prodFixed = negRes_q ? (~work_q + 1'b1) : work_q;
        quoFixed  = negRes_q ? (~work_q[XLEN-1:0] + 1'b1) : work_q[XLEN-1:0];
        remFixed  = negRem_q ? (~work_q[2*XLEN-1:XLEN] + 1'b1)
                             : work_q[2*XLEN-1:XLEN];
    end

    // Next-state and output logic. Status flags default low so they are
    // only ever high for the single RESP cycle.
    always_comb begin : nextStateLogic
        state_d   = state_q;
        cnt_d     = cnt_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        work_d    = work_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        isDiv_d   = isDiv_q;
        aluCtl_d  = aluCtl_q;
        useHilo_d = useHilo_q;
        hiloRes_d = hiloRes_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        divZero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (opKind)
                        OP_ALU: begin
                            aluCtl_d  = decCode;
                            useHilo_d = 1'b0;
                            done_d    = 1'b1;
                            state_d   = RESP;
                        end
                        OP_MFHI: begin
                            useHilo_d = 1'b1;
                            hiloRes_d = hi_q;
                            done_d    = 1'b1;
                            state_d   = RESP;
                        end
                        OP_MFLO: begin
                            useHilo_d = 1'b1;
                            hiloRes_d = lo_q;
                            done_d    = 1'b1;
                            state_d   = RESP;
                        end
                        OP_MULT: begin
                            opA_d     = absRs;
                            work_d    = {{XLEN{1'b0}}, absRt};
                            negRes_d  = rs_data[XLEN-1] ^ rt_data[XLEN-1];
                            isDiv_d   = 1'b0;
                            cnt_d     = '0;
                            useHilo_d = 1'b0;
                            state_d   = MUL;
                        end
                        OP_DIV: begin
                            useHilo_d = 1'b0;
                            if (rt_data == '0) begin
                                // Divide by zero bypasses the iterations.
                                hi_d      = rs_data;
                                lo_d      = '1;
                                divZero_d = 1'b1;
                                done_d    = 1'b1;
                                state_d   = RESP;
                            end else begin
                                opB_d    = absRt;
                                work_d   = {{XLEN{1'b0}}, absRs};
                                negRes_d = rs_data[XLEN-1] ^ rt_data[XLEN-1];
                                negRem_d = rs_data[XLEN-1];
                                isDiv_d  = 1'b1;
                                cnt_d    = '0;
                                state_d  = DIV;
                            end
                        end
                        default: begin
                            aluCtl_d  = 4'b0000;
                            useHilo_d = 1'b0;
                            illegal_d = 1'b1;
                            done_d    = 1'b1;
                            state_d   = RESP;
                        end
                    endcase
                end
            end
            MUL: begin
                work_d = mulNext;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                work_d = divNext;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    hi_d = remFixed;
                    lo_d = quoFixed;
                end else begin
                    hi_d = prodFixed[2*XLEN-1:XLEN];
                    lo_d = prodFixed[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            work_q    <= '0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            isDiv_q   <= 1'b0;
            aluCtl_q  <= 4'b0000;
            useHilo_q <= 1'b0;
            hiloRes_q <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            work_q    <= work_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            isDiv_q   <= isDiv_d;
            aluCtl_q  <= aluCtl_d;
            useHilo_q <= useHilo_d;
            hiloRes_q <= hiloRes_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign op_ready    = (state_q == IDLE);
    assign ALU_Control = aluCtl_q;
    assign use_hilo    = useHilo_q;
    assign hilo_result = hiloRes_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign div_zero    = divZero_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_control_seq
//
// Purpose:
//   Directed and randomized checks of alu_control_seq against a behavioural
//   model that computes results with plain signed arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_control_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  ALUOp = 2'b00;
    logic [5:0]  funct = 6'b000000;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic [3:0]  ALU_Control;
    logic        use_hilo;
    logic [31:0] hilo_result;
    logic        done;
    logic        illegal;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad = 0;
    int obsLat;

    // Behavioural model state
    logic [31:0] mHi = 32'h0;
    logic [31:0] mLo = 32'h0;
    logic [3:0]  mAlu = 4'b0000;
    logic        mUse = 1'b0;
    logic [31:0] expHilo = 32'h0;
    int          expLat;
    logic        expIll;
    logic        expDz;
    logic        expMf;

    alu_control_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .ALUOp       (ALUOp),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .ALU_Control (ALU_Control),
        .use_hilo    (use_hilo),
        .hilo_result (hilo_result),
        .done        (done),
        .illegal     (illegal),
        .div_zero    (div_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: updates expected architectural state for one op.
    task automatic modelOp(input logic [1:0] aop, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        expLat = 1;
        expIll = 1'b0;
        expDz  = 1'b0;
        expMf  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (aop)
            2'b00: begin mAlu = 4'b0010; mUse = 1'b0; end
            2'b01: begin mAlu = 4'b0110; mUse = 1'b0; end
            2'b11: begin mAlu = 4'b0111; mUse = 1'b0; end
            default: begin
                case (fn)
                    6'b100000: begin mAlu = 4'b0010; mUse = 1'b0; end
                    6'b100010: begin mAlu = 4'b0110; mUse = 1'b0; end
                    6'b100100: begin mAlu = 4'b0000; mUse = 1'b0; end
                    6'b100101: begin mAlu = 4'b0001; mUse = 1'b0; end
                    6'b100111: begin mAlu = 4'b1100; mUse = 1'b0; end
                    6'b101010: begin mAlu = 4'b0111; mUse = 1'b0; end
                    6'b011000: begin
                        p = sa * sb;
                        mHi = p[63:32];
                        mLo = p[31:0];
                        mUse = 1'b0;
                        expLat = 34;
                    end
                    6'b011010: begin
                        mUse = 1'b0;
                        if (b == 32'h0) begin
                            mHi = a;
                            mLo = 32'hFFFFFFFF;
                            expDz = 1'b1;
                        end else begin
                            q = sa / sb;
                            r = sa % sb;
                            p = q;
                            mLo = p[31:0];
                            p = r;
                            mHi = p[31:0];
                            expLat = 34;
                        end
                    end
                    6'b010000: begin mUse = 1'b1; expHilo = mHi; expMf = 1'b1; end
                    6'b010010: begin mUse = 1'b1; expHilo = mLo; expMf = 1'b1; end
                    default: begin mAlu = 4'b0000; mUse = 1'b0; expIll = 1'b1; end
                endcase
            end
        endcase
    endtask

    // Issues one request and waits (bounded) for done; obsLat counts sample
    // points after the accepting edge. Optional pokes of op_valid while busy.
    task automatic applyStimulus(input logic [1:0] aop, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit pokeBusy);
        int guard = 0;
        while (op_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        ALUOp    = aop;
        funct    = fn;
        rs_data  = a;
        rt_data  = b;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        obsLat = 1;
        while (done !== 1'b1 && obsLat < 100) begin
            if (pokeBusy && (obsLat == 5 || obsLat == 20)) begin
                op_valid = 1'b1;
                ALUOp    = 2'b10;
                funct    = 6'b010000;
                rs_data  = $urandom;
            end
            @(posedge clk); #1;
            op_valid = 1'b0;
            obsLat++;
        end
        op_valid = 1'b0;
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, ".latency"}, 64'(obsLat), 64'(expLat));
        checkOutput({tag, ".done"}, 64'(done), 64'(1'b1));
        checkOutput({tag, ".op_ready_busy"}, 64'(op_ready), 64'(1'b0));
        checkOutput({tag, ".illegal"}, 64'(illegal), 64'(expIll));
        checkOutput({tag, ".div_zero"}, 64'(div_zero), 64'(expDz));
        checkOutput({tag, ".ALU_Control"}, 64'(ALU_Control), 64'(mAlu));
        checkOutput({tag, ".use_hilo"}, 64'(use_hilo), 64'(mUse));
        checkOutput({tag, ".hi"}, 64'(hi_out), 64'(mHi));
        checkOutput({tag, ".lo"}, 64'(lo_out), 64'(mLo));
        if (expMf) begin
            checkOutput({tag, ".hilo_result"}, 64'(hilo_result), 64'(expHilo));
        end
        @(posedge clk); #1;
        checkOutput({tag, ".done_drop"}, 64'(done), 64'(1'b0));
        checkOutput({tag, ".op_ready_back"}, 64'(op_ready), 64'(1'b1));
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'hFFFFFFFF;
            2:       v = 32'h80000000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] pickFunct();
        logic [5:0] v;
        case ($urandom_range(0, 10))
            0:       v = 6'b100000;
            1:       v = 6'b100010;
            2:       v = 6'b100100;
            3:       v = 6'b100101;
            4:       v = 6'b100111;
            5:       v = 6'b101010;
            6:       v = 6'b011000;
            7:       v = 6'b011010;
            8:       v = 6'b010000;
            9:       v = 6'b010010;
            default: v = 6'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [1:0]  rAop;
        logic [5:0]  rFn;
        logic [31:0] rA, rB;

        // Power-on reset
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.ALU_Control", 64'(ALU_Control), 64'(4'b0000));
        checkOutput("reset.use_hilo", 64'(use_hilo), 64'(1'b0));
        checkOutput("reset.hilo_result", 64'(hilo_result), 64'(32'h0));
        checkOutput("reset.done", 64'(done), 64'(1'b0));
        checkOutput("reset.illegal", 64'(illegal), 64'(1'b0));
        checkOutput("reset.div_zero", 64'(div_zero), 64'(1'b0));
        checkOutput("reset.hi", 64'(hi_out), 64'(32'h0));
        checkOutput("reset.lo", 64'(lo_out), 64'(32'h0));
        checkOutput("reset.op_ready", 64'(op_ready), 64'(1'b1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // nor
        modelOp(2'b10, 6'b100111, 32'h0, 32'h0);
        applyStimulus(2'b10, 6'b100111, 32'h0, 32'h0, 1'b0);
        checkResult("nor");

        // mult -3 * 7 with ignored requests while busy
        modelOp(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h7);
        applyStimulus(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h7, 1'b1);
        checkOutput("mult.hi_const", 64'(hi_out), 64'(32'hFFFFFFFF));
        checkOutput("mult.lo_const", 64'(lo_out), 64'(32'hFFFFFFEB));
        checkResult("mult");

        // div -7 / 2 then mflo
        modelOp(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h2);
        applyStimulus(2'b10, 6'b011010, 32'hFFFFFFF9, 32'h2, 1'b0);
        checkOutput("div.lo_const", 64'(lo_out), 64'(32'hFFFFFFFD));
        checkOutput("div.hi_const", 64'(hi_out), 64'(32'hFFFFFFFF));
        checkResult("div");
        modelOp(2'b10, 6'b010010, 32'h0, 32'h0);
        applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0, 1'b0);
        checkOutput("mflo.value", 64'(hilo_result), 64'(32'hFFFFFFFD));
        checkResult("mflo");

        // divide by zero
        modelOp(2'b10, 6'b011010, 32'h12345678, 32'h0);
        applyStimulus(2'b10, 6'b011010, 32'h12345678, 32'h0, 1'b0);
        checkResult("divzero");

        // reset in the middle of a multiply
        ALUOp = 2'b10; funct = 6'b011000; rs_data = 32'd5; rt_data = 32'd6;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        mHi = 32'h0; mLo = 32'h0; mAlu = 4'b0000; mUse = 1'b0;
        checkOutput("midreset.done", 64'(done), 64'(1'b0));
        checkOutput("midreset.ALU_Control", 64'(ALU_Control), 64'(mAlu));
        checkOutput("midreset.use_hilo", 64'(use_hilo), 64'(mUse));
        checkOutput("midreset.hilo_result", 64'(hilo_result), 64'(32'h0));
        checkOutput("midreset.op_ready", 64'(op_ready), 64'(1'b1));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postreset.hi", 64'(hi_out), 64'(mHi));
        checkOutput("postreset.lo", 64'(lo_out), 64'(mLo));
        checkOutput("postreset.op_ready", 64'(op_ready), 64'(1'b1));
        checkOutput("postreset.done", 64'(done), 64'(1'b0));

        // load HI/LO, then an illegal funct must leave them alone
        modelOp(2'b10, 6'b011000, 32'h80000000, 32'h80000000);
        applyStimulus(2'b10, 6'b011000, 32'h80000000, 32'h80000000, 1'b0);
        checkResult("mult_min");
        modelOp(2'b10, 6'b111111, 32'hDEADBEEF, 32'h1);
        applyStimulus(2'b10, 6'b111111, 32'hDEADBEEF, 32'h1, 1'b0);
        checkResult("illegal");

        // mfhi immediately after a divide completes; then min / -1 wrap
        modelOp(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
        applyStimulus(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        checkOutput("divwrap.lo_const", 64'(lo_out), 64'(32'h80000000));
        checkOutput("divwrap.hi_const", 64'(hi_out), 64'(32'h0));
        checkResult("divwrap");
        modelOp(2'b10, 6'b010000, 32'h0, 32'h0);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0, 1'b0);
        checkResult("mfhi");

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            rAop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) rAop = 2'b10;
            rFn = pickFunct();
            rA  = pickOperand();
            rB  = pickOperand();
            modelOp(rAop, rFn, rA, rB);
            applyStimulus(rAop, rFn, rA, rB, $urandom_range(0, 1) == 1);
            checkResult($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Control-side counterpart of the datapath ALU: decodes ALUOp/funct into the 4-bit ALU_Control code that the ALU consumes.
- Owns the HI/LO registers and executes signed mult/div iteratively (radix-2, one bit per cycle); serves mfhi/mflo.
- Sits between the main control/decode stage and the ALU, with a valid/ready handshake so the control FSM stalls during multi-cycle ops.

Parameters:
- XLEN, 32, operand/result width; HI/LO are XLEN each; iteration count = XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  operation request
- op_ready  output  1  block can accept; high only in IDLE
- ALUOp  input  2  main-control op class
- funct  input  6  R-type function field
- rs_data  input  XLEN  operand A (mult/div)
- rt_data  input  XLEN  operand B (mult/div)
- ALU_Control  output  4  code to ALU
- use_hilo  output  1  writeback selects hilo_result instead of ALU result
- hilo_result  output  XLEN  HI or LO value for mfhi/mflo
- done  output  1  one-cycle completion pulse
- illegal  output  1  valid with done; unsupported encoding
- div_zero  output  1  valid with done; divide by zero
- hi_out, lo_out  output  XLEN each  current HI/LO

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous active-low, rst_n.
- Reset values: ALU_Control=0000, use_hilo=0, hilo_result=0, done=0, illegal=0, div_zero=0, HI=LO=0, state=IDLE (op_ready=1). Reset mid-op aborts; partial results discarded.
- Accept on a rising edge with op_valid && op_ready. op_valid while op_ready=0 is ignored (no queueing). All outputs registered.
- Decode:
  - ALUOp 00 -> 0010 (add).
  - ALUOp 01 -> 0110 (sub).
  - ALUOp 11 -> 0111 (slt).
  - ALUOp 10 uses funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111; 011000=mult, 011010=div, 010000=mfhi, 010010=mflo; any other funct is illegal.
- Single-cycle ops (ALU codes, mfhi, mflo, illegal):
  - IDLE -> RESP. Cycle after accept: ALU_Control/use_hilo/hilo_result/flags valid, done=1, op_ready=0. Then back to IDLE.
  - mfhi/mflo: use_hilo=1, hilo_result=HI/LO, ALU_Control unchanged.
  - Illegal: illegal=1, ALU_Control=0000, HI/LO untouched.
  - ALU_Control and use_hilo hold until the next accepted op.
- mult (signed):
  - Accept: latch |rs|, |rt| and sign = rs[31]^rt[31]; ALU_Control unchanged; state MUL.
  - MUL: 32 shift-add iterations, counter 0..31.
  - FIX: negate the 64-bit product if sign; write HI=[63:32], LO=[31:0].
  - RESP: done=1. done is high exactly 34 cycles after the accepting edge (1 latch + 32 iterations + 1 fix). HI/LO show new values when done=1.
- div (signed):
  - Same flow as mult (DIV state, 32 restoring iterations, FIX, RESP); same 34-cycle latency.
  - LO = quotient (sign = xor of operand signs); HI = remainder (sign = dividend sign).
  - -2^31 / -1 gives LO=0x80000000, HI=0 (natural wrap, no flag).
  - rt=0: skip iterations; go straight to RESP with HI=rs, LO=0xFFFFFFFF, div_zero=1; done 1 cycle after accept.
- mfhi accepted the cycle after a mult/div done returns the new HI.
- States: IDLE, MUL, DIV, FIX, RESP. op_ready=1 only in IDLE.

Test Plan:
- ALUOp=10, funct=100111, op_valid 1 cycle -> next cycle done=1, ALU_Control=1100, use_hilo=0, illegal=0; op_ready high the cycle after.
- mult rs=0xFFFFFFFD (-3), rt=7 -> done exactly 34 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB; op_valid pulses during busy are ignored.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_zero=0; then mflo -> use_hilo=1, hilo_result=0xFFFFFFFD.
- div rs=0x12345678, rt=0 -> done 1 cycle after accept, div_zero=1, HI=0x12345678, LO=0xFFFFFFFF.
- mult 5*6 started, rst_n low at iteration 10 -> all outputs at reset values immediately; after release HI=LO=0, op_ready=1.
- ALUOp=10, funct=111111 -> done=1, illegal=1, ALU_Control=0000, HI/LO unchanged.
